vga_text_overlay: RTL

VGA_TEXT_OVERLAY -- requirements
Module: vga_text_overlay

---
 rtl/vga_text_overlay.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/vga_text_overlay.sv
// vga_text_overlay
//   VGA timing generator with a single monochrome text/glyph strip overlaid
//   on the active area. The glyph strip is TEXT_W x TEXT_H bits and is read
//   one row per ROM word from an external ROM (latency <= 1 clk). It can be
//   placed anywhere, magnified by 1/2/4/8, and is clipped to the active area.
//
// Ports
//   clk, rst_n          sole clock, synchronous active-low reset
//   cfg_we, cfg_*       configuration write into staging registers
//   rom_addr/rom_data   glyph row address out, glyph row in (MSB = leftmost)
//   hsync, vsync        active-low syncs, aligned with RGB
//   de                  active video, aligned with RGB
//   vga_r/g/b           RGB444 pixel colour
//   frame_start         one-clk pulse when the active config is reloaded
module vga_text_overlay #(
   parameter int CLK_DIV  = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int TEXT_W   = 128,
   parameter int TEXT_H   = 32,
   localparam int AW      = $clog2(TEXT_H)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [10:0]       cfg_x,
   input  logic [10:0]       cfg_y,
   input  logic [1:0]        cfg_scale,
   input  logic [11:0]       cfg_fg,
   input  logic [11:0]       cfg_bg,
   input  logic              cfg_en,
   output logic [AW-1:0]     rom_addr,
   input  logic [TEXT_W-1:0] rom_data,
   output logic              hsync,
   output logic              vsync,
   output logic              de,
   output logic [3:0]        vga_r,
   output logic [3:0]        vga_g,
   output logic [3:0]        vga_b,
   output logic              frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = $clog2(CLK_DIV);
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int CW      = $clog2(TEXT_W);

   typedef struct packed {
      logic [10:0] x;
      logic [10:0] y;
      logic [1:0]  scale;
      logic [11:0] fg;
      logic [11:0] bg;
      logic        en;
   } cfg_t;

   localparam cfg_t CFG_RST = '{x: 11'd0, y: 11'd0, scale: 2'd0,
                                fg: 12'hFFF, bg: 12'h000, en: 1'b0};

   // pixel tick and raster counters
   logic [DW-1:0] div_q, div_d;
   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic          tick, h_end, v_end, wrap;

   // configuration
   cfg_t          stg_q, act_q, cfg_in;

   // stage 1: ROM address, bit index, hit flag, raw syncs
   logic [AW-1:0] rom_addr_q, rom_addr_d;
   logic [CW-1:0] bidx_q, bidx_d;
   logic          hit1_q, hit1_d;
   logic          de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;

   // stage 2: colour and aligned syncs
   logic [11:0]   rgb_q, rgb_d;
   logic          de_q, hs_q, vs_q, fs_q;

   // 13-bit placement arithmetic; the extra headroom keeps h-x0 from
   // wrapping into a false hit when the origin is beyond the raster
   logic [12:0]   h13, v13, x13, y13, dx, dy, col, row;
   logic          in_h, in_v;
   logic          unused_bits;

   assign tick   = (div_q == DW'(CLK_DIV - 1));
   assign h_end  = (h_q == HW'(H_TOTAL - 1));
   assign v_end  = (v_q == VW'(V_TOTAL - 1));
   assign wrap   = tick && h_end && v_end;

   assign cfg_in = '{x: cfg_x, y: cfg_y, scale: cfg_scale,
                     fg: cfg_fg, bg: cfg_bg, en: cfg_en};

   always_comb begin
      div_d = tick ? '0 : div_q + 1'b1;
      h_d   = h_q;
      v_d   = v_q;
      if (tick) begin
         if (h_end) begin
            h_d = '0;
            v_d = v_end ? '0 : v_q + 1'b1;
         end else begin
            h_d = h_q + 1'b1;
         end
      end
   end

   always_comb begin
      h13  = 13'(h_q);
      v13  = 13'(v_q);
      x13  = {2'b00, act_q.x};
      y13  = {2'b00, act_q.y};
      dx   = h13 - x13;
      dy   = v13 - y13;
      in_h = (h13 >= x13) && (dx < (13'(TEXT_W) << act_q.scale));
      in_v = (v13 >= y13) && (dy < (13'(TEXT_H) << act_q.scale));
      col  = dx >> act_q.scale;
      row  = dy >> act_q.scale;

      rom_addr_d = in_v ? row[AW-1:0] : '0;
      bidx_d     = CW'(TEXT_W - 1) - col[CW-1:0];
      hit1_d     = act_q.en && in_h && in_v;
      de1_d      = (h13 < 13'(H_ACTIVE)) && (v13 < 13'(V_ACTIVE));
      hs1_d      = !((h13 >= 13'(H_ACTIVE + H_FP)) &&
                     (h13 <  13'(H_ACTIVE + H_FP + H_SYNC)));
      vs1_d      = !((v13 >= 13'(V_ACTIVE + V_FP)) &&
                     (v13 <  13'(V_ACTIVE + V_FP + V_SYNC)));

      // rom_data belongs to rom_addr_q, set one tick earlier
      if (!de1_q)
         rgb_d = '0;
      else if (hit1_q && rom_data[bidx_q])
         rgb_d = act_q.fg;
      else
         rgb_d = act_q.bg;
   end

   // upper bits of col/row are only nonzero outside the strip, where they
   // are masked by in_h/in_v
   assign unused_bits = ^{col[12:CW], row[12:AW]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_q      <= '0;
         h_q        <= '0;
         v_q        <= '0;
         stg_q      <= CFG_RST;
         act_q      <= CFG_RST;
         rom_addr_q <= '0;
         bidx_q     <= '0;
         hit1_q     <= 1'b0;
         de1_q      <= 1'b0;
         hs1_q      <= 1'b1;
         vs1_q      <= 1'b1;
         rgb_q      <= '0;
         de_q       <= 1'b0;
         hs_q       <= 1'b1;
         vs_q       <= 1'b1;
         fs_q       <= 1'b0;
      end else begin
         div_q <= div_d;
         h_q   <= h_d;
         v_q   <= v_d;
         if (cfg_we) stg_q <= cfg_in;
         // same-edge cfg_we lands in staging only, so it takes a frame longer
         if (wrap)   act_q <= stg_q;
         fs_q  <= wrap;
         if (tick) begin
            rom_addr_q <= rom_addr_d;
            bidx_q     <= bidx_d;
            hit1_q     <= hit1_d;
            de1_q      <= de1_d;
            hs1_q      <= hs1_d;
            vs1_q      <= vs1_d;
            rgb_q      <= rgb_d;
            de_q       <= de1_q;
            hs_q       <= hs1_q;
            vs_q       <= vs1_q;
         end
      end
   end

   assign rom_addr    = rom_addr_q;
   assign hsync       = hs_q;
   assign vsync       = vs_q;
   assign de          = de_q;
   assign vga_r       = rgb_q[11:8];
   assign vga_g       = rgb_q[7:4];
   assign vga_b       = rgb_q[3:0];
   assign frame_start = fs_q;

endmodule
